// File: rtl/lcd_hd44780_writer_if.sv
// ============================================================================
// Module   : lcd_hd44780_writer_if
// Brief    : Write-strobe side and LCD pin side of the HD44780 write engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_hd44780_writer_if;
  logic       wr;
  logic       wr_rs;
  logic       wr_nib;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
  logic       err_clr;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [3:0] lcd_db;

  modport master (
    output wr, wr_rs, wr_nib, wr_data, err_clr,
    input  busy, err, lcd_e, lcd_rw, lcd_rs, lcd_db
  );

  modport slave (
    input  wr, wr_rs, wr_nib, wr_data, err_clr,
    output busy, err, lcd_e, lcd_rw, lcd_rs, lcd_db
  );
endinterface

`default_nettype wire

// File: rtl/lcd_hd44780_writer.sv
// ============================================================================
// Module   : lcd_hd44780_writer
// Brief    : HD44780 4-bit bus write engine with E timing and execution wait.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_hd44780_writer #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_HIGH_CYC    = 13,
  parameter int unsigned GAP_CYC       = 27,
  parameter int unsigned EXEC_CYC      = 1080,
  parameter int unsigned LONG_EXEC_CYC = 41040,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  lcd_hd44780_writer_if.slave  bus
);

  generate
    if (SETUP_CYC < 1 || E_HIGH_CYC < 1 || GAP_CYC < 1 || EXEC_CYC < 1 ||
        LONG_EXEC_CYC < 1 || (SETUP_CYC >> CNT_W) != 0 ||
        (E_HIGH_CYC >> CNT_W) != 0 || (GAP_CYC >> CNT_W) != 0 ||
        (EXEC_CYC >> CNT_W) != 0 || (LONG_EXEC_CYC >> CNT_W) != 0) begin : g_bad_params
      $error("lcd_hd44780_writer: cycle parameters must be >= 1 and < 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_ehigh_ld = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap_ld   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_exec_ld  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] c_long_ld  = CNT_W'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EHIGH = 3'd2,
    S_GAP   = 3'd3,
    S_EXEC  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_busy;
  logic             r_err;
  logic             r_lcd_e;
  logic             r_lcd_rs;
  logic [3:0]       r_lcd_db;
  logic [3:0]       r_lo_nib;
  logic             r_second;
  logic             r_long;
  logic             w_long;
  logic             w_tmo;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait
  assign w_long = !bus.wr_rs && !bus.wr_nib && (bus.wr_data[7:2] == 6'd0) &&
                  (bus.wr_data[1:0] != 2'd0);
  assign w_tmo  = (r_timer == '0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_lcd_e  <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_lcd_db <= 4'd0;
      r_lo_nib <= 4'd0;
      r_second <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      if (bus.wr && r_busy) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.wr) begin
            r_state  <= S_SETUP;
            r_timer  <= c_setup_ld;
            r_busy   <= 1'b1;
            r_lcd_rs <= bus.wr_rs;
            r_lcd_db <= bus.wr_nib ? bus.wr_data[3:0] : bus.wr_data[7:4];
            r_lo_nib <= bus.wr_data[3:0];
            r_second <= !bus.wr_nib;
            r_long   <= w_long;
          end
        end
        S_SETUP: begin
          if (w_tmo) begin
            r_state <= S_EHIGH;
            r_timer <= c_ehigh_ld;
            r_lcd_e <= 1'b1;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        S_EHIGH: begin
          if (w_tmo) begin
            r_state <= S_GAP;
            r_timer <= c_gap_ld;
            r_lcd_e <= 1'b0;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (w_tmo) begin
            if (r_second) begin
              r_state  <= S_SETUP;
              r_timer  <= c_setup_ld;
              r_lcd_db <= r_lo_nib;
              r_second <= 1'b0;
            end else begin
              r_state <= S_EXEC;
              r_timer <= r_long ? c_long_ld : c_exec_ld;
            end
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (w_tmo) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_lcd_e <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.err    = r_err;
  assign bus.lcd_e  = r_lcd_e;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_rs = r_lcd_rs;
  assign bus.lcd_db = r_lcd_db;

endmodule

`default_nettype wire
